// File: rtl/jt03_wrq_pkg.sv
// jt03_wrq_pkg: shared types and constants for the jt03_wrq write queue.
//   state_t    - sequencer states (IDLE, ADDR, AWAIT, DATA, BUSY)
//   BUSY_BIT   - busy flag position in the chip status byte
//   wait_width - wait-counter width able to hold the larger of the two waits
package jt03_wrq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AWAIT,
    ST_DATA,
    ST_BUSY
  } state_t;

  localparam int unsigned BUSY_BIT = 7;

  function automatic int unsigned wait_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/jt03_wrq_fifo.sv
// jt03_wrq_fifo: synchronous first-word-fall-through FIFO, 2^AW entries.
//   rst/clk    - async active-high reset, clock
//   wr/din     - push strobe and data (accepted when not full, or when popping)
//   rd/dout    - pop strobe (ignored when empty) and head of queue
//   full/empty - occupancy flags
//   level      - occupancy, 0 .. 2^AW
module jt03_wrq_fifo #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A simultaneous pop frees a slot, so a push is taken even when full.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jt03_wrq.sv
// jt03_wrq: register-write queue and bus sequencer in front of the YM2203
// wrapper. Host pushes (reg,val) pairs; each is replayed as an address
// write, ADDR_WAIT idle ticks, a data write, then a busy interval.
//   rst, clk, cen               - async reset, clock, chip clock enable
//   wr_req, wr_reg, wr_val      - host push interface
//   full, empty, level, ovf     - queue status (ovf sticky until rst)
//   idle                        - queue empty and sequencer idle
//   chip_din/addr/cs_n/wr_n     - registered chip bus outputs
//   chip_dout                   - chip status input (bit 7 = busy)
// Build option: JT03_WRQ_BUSY_EN - BUSY polls the status register instead of
// counting DATA_WAIT ticks.
module jt03_wrq
  import jt03_wrq_pkg::*;
#(
  parameter int AW        = 4,
  parameter int ADDR_WAIT = 4,
  parameter int DATA_WAIT = 24
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        wr_req,
  input  logic [7:0]  wr_reg,
  input  logic [7:0]  wr_val,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        ovf,
  output logic        idle,
  output logic [7:0]  chip_din,
  output logic        chip_addr,
  output logic        chip_cs_n,
  output logic        chip_wr_n,
  input  logic [7:0]  chip_dout
);

  localparam int unsigned CW = wait_width(ADDR_WAIT, DATA_WAIT);
  localparam logic [CW-1:0] ADDR_LOAD = CW'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
`ifndef JT03_WRQ_BUSY_EN
  localparam logic [CW-1:0] DATA_LOAD = CW'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   head;
  logic          pop;
  logic          dout_unused;
`ifdef JT03_WRQ_BUSY_EN
  logic          first_poll;
`endif

  assign dout_unused = &chip_dout;
  assign pop  = cen & (state == ST_DATA);
  assign idle = empty & (state == ST_IDLE);

  jt03_wrq_fifo #(.AW(AW), .DW(16)) u_fifo (
    .rst   (rst),
    .clk   (clk),
    .wr    (wr_req),
    .din   ({wr_reg, wr_val}),
    .rd    (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Drops only happen when full and no pop frees a slot this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (wr_req && full && !pop) ovf <= 1'b1;
  end

  // Bus outputs are produced on the tick a state is left, so each strobe
  // is registered and lasts exactly one cen tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      chip_din  <= '0;
      chip_addr <= 1'b0;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
`ifdef JT03_WRQ_BUSY_EN
      first_poll <= 1'b0;
`endif
    end else if (cen) begin
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_ADDR;
        end
        ST_ADDR: begin
          chip_addr <= 1'b0;
          chip_din  <= head[15:8];
          chip_cs_n <= 1'b0;
          chip_wr_n <= 1'b0;
          cnt       <= ADDR_LOAD;
          state     <= ST_AWAIT;
        end
        ST_AWAIT: begin
          if (cnt == '0) state <= ST_DATA;
          else cnt <= cnt - 1'b1;
        end
        ST_DATA: begin
          chip_addr <= 1'b1;
          chip_din  <= head[7:0];
          chip_cs_n <= 1'b0;
          chip_wr_n <= 1'b0;
          state     <= ST_BUSY;
`ifdef JT03_WRQ_BUSY_EN
          first_poll <= 1'b1;
`else
          cnt <= DATA_LOAD;
`endif
        end
        ST_BUSY: begin
`ifdef JT03_WRQ_BUSY_EN
          // First tick only opens the status read; the status byte is
          // meaningful from the next tick on.
          chip_addr <= 1'b0;
          chip_cs_n <= 1'b0;
          if (first_poll) begin
            first_poll <= 1'b0;
          end else if (!chip_dout[BUSY_BIT]) begin
            chip_cs_n <= 1'b1;
            state     <= ST_IDLE;
          end
`else
          if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - 1'b1;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt03_wrq.sv
// tb_jt03_wrq: directed self-checking bench for jt03_wrq (AW=4, ADDR_WAIT=4,
// DATA_WAIT=24). Bus strobes are logged by a monitor and compared against
// hand-computed expectations.
module tb_jt03_wrq;

  logic       rst, clk, cen, wr_req;
  logic [7:0] wr_reg, wr_val, chip_dout;
  logic       full, empty, ovf, idle, chip_addr, chip_cs_n, chip_wr_n;
  logic [4:0] level;
  logic [7:0] chip_din;

  jt03_wrq #(.AW(4), .ADDR_WAIT(4), .DATA_WAIT(24)) dut (
    .rst(rst), .clk(clk), .cen(cen), .wr_req(wr_req), .wr_reg(wr_reg),
    .wr_val(wr_val), .full(full), .empty(empty), .level(level), .ovf(ovf),
    .idle(idle), .chip_din(chip_din), .chip_addr(chip_addr),
    .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n), .chip_dout(chip_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cen_div = 1;   // 0: cen low, 1: always high, N: one in N clocks
  int cen_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      if (cen_div == 0) cen = 1'b0;
      else if (cen_div == 1) cen = 1'b1;
      else begin
        cen = (cen_cnt == 0);
        cen_cnt = (cen_cnt + 1) % cen_div;
      end
    end
  end

  typedef struct {
    logic       a;
    logic [7:0] d;
    int         start;
    int         dur;
    int         lvl;
  } strobe_t;

  strobe_t log_q[$];
  strobe_t cur;
  bit      in_s = 0;

  always @(negedge clk) begin
    if (rst) in_s = 0;
    else if (!chip_wr_n && !chip_cs_n) begin
      if (!in_s) begin
        in_s = 1;
        cur.a = chip_addr; cur.d = chip_din; cur.start = cyc;
        cur.dur = 1; cur.lvl = int'(level);
      end else cur.dur++;
    end else if (in_s) begin
      in_s = 0;
      log_q.push_back(cur);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    wr_req = 1'b1; wr_reg = r; wr_val = v;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle) begin at = cyc; break; end
    end
    chk("idle_timeout", int'(at >= 0), 1);
  endtask

  task automatic wait_strobe(input bit want_data, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!chip_wr_n && !chip_cs_n && chip_addr == want_data) begin at = cyc; break; end
    end
    chk("strobe_timeout", int'(at >= 0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, int'(chip_cs_n), 1);
    chk({tag, "_wr_n"}, int'(chip_wr_n), 1);
    chk({tag, "_addr"}, int'(chip_addr), 0);
    chk({tag, "_din"}, int'(chip_din), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_idle"}, int'(idle), 1);
  endtask

  typedef struct {
    logic [7:0] r;
    logic [7:0] v;
    int         lvl_push;
    int         lvl_data;
  } vec_t;

  vec_t tbl[3];
  int p, at, d, nd;

  initial begin
    tbl[0] = '{8'h28, 8'hF0, 1, 2};
    tbl[1] = '{8'hA4, 8'h22, 2, 1};
    tbl[2] = '{8'h07, 8'h3C, 3, 0};

    rst = 1'b1; wr_req = 1'b0; wr_reg = '0; wr_val = '0; chip_dout = '0;
    cen_div = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Single write, cen always high.
`ifndef JT03_WRQ_BUSY_EN
    chip_dout = 8'hFF;
`endif
    log_q.delete();
    push(8'h28, 8'hF0);
    p = cyc;
    wait_idle(200, at);
    chk("t1_nlog", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t1_a_addr", int'(log_q[0].a), 0);
      chk("t1_a_din", int'(log_q[0].d), 8'h28);
      chk("t1_a_start", log_q[0].start, p + 2);
      chk("t1_a_dur", log_q[0].dur, 1);
      chk("t1_d_addr", int'(log_q[1].a), 1);
      chk("t1_d_din", int'(log_q[1].d), 8'hF0);
      chk("t1_d_gap", log_q[1].start - log_q[0].start, 5);
      chk("t1_d_dur", log_q[1].dur, 1);
    end
`ifdef JT03_WRQ_BUSY_EN
    chk("t1_idle_at", at, p + 9);
`else
    chk("t1_idle_at", at, p + 31);
`endif
    chip_dout = '0;

    // Three back-to-back entries, cen one clock in six.
    cen_div = 6;
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_reg = tbl[i].r; wr_val = tbl[i].v;
      @(negedge clk);
      chk("t2_lvl_push", int'(level), tbl[i].lvl_push);
    end
    wr_req = 1'b0;
    wait_idle(3000, at);
    chk("t2_nlog", log_q.size(), 6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_a_addr", int'(log_q[2*i].a), 0);
        chk("t2_a_din", int'(log_q[2*i].d), int'(tbl[i].r));
        chk("t2_a_dur", log_q[2*i].dur, 6);
        chk("t2_d_addr", int'(log_q[2*i+1].a), 1);
        chk("t2_d_din", int'(log_q[2*i+1].d), int'(tbl[i].v));
        chk("t2_d_dur", log_q[2*i+1].dur, 6);
        chk("t2_lvl_data", log_q[2*i+1].lvl, tbl[i].lvl_data);
      end
      chk("t2_gap", log_q[1].start - log_q[0].start, 30);
    end

    // Overflow: fill with cen low, 17th push dropped.
    cen_div = 0;
    do_reset();
    log_q.delete();
    for (int i = 0; i < 16; i++) push(8'(i + 16), 8'(255 - i));
    chk("t3_full", int'(full), 1);
    chk("t3_level", int'(level), 16);
    chk("t3_ovf_before", int'(ovf), 0);
    push(8'hAA, 8'h55);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_level_after", int'(level), 16);
    cen_div = 1;
    wait_idle(3000, at);
    chk("t3_nlog", log_q.size(), 32);
    for (int i = 0; i < 16 && 2*i+1 < log_q.size(); i++) begin
      chk("t3_a_din", int'(log_q[2*i].d), i + 16);
      chk("t3_d_din", int'(log_q[2*i+1].d), 255 - i);
    end
    chk("t3_ovf_sticky", int'(ovf), 1);

    // Full queue: push on the same edge as the DATA pop.
    cen_div = 0;
    do_reset();
    log_q.delete();
    for (int i = 0; i < 16; i++) push(8'(i + 16), 8'(255 - i));
    cen_div = 1;
    wait_strobe(1'b0, 50, at);
    repeat (4) @(negedge clk);
    chk("t4_pre_full", int'(full), 1);
    push(8'hEE, 8'h77);
    chk("t4_data_strobe", int'(!chip_cs_n && !chip_wr_n && chip_addr), 1);
    chk("t4_level", int'(level), 16);
    chk("t4_ovf", int'(ovf), 0);
    chk("t4_full", int'(full), 1);
    wait_idle(3000, at);
    chk("t4_nlog", log_q.size(), 34);
    if (log_q.size() == 34) begin
      chk("t4_last_reg", int'(log_q[32].d), 8'hEE);
      chk("t4_last_val", int'(log_q[33].d), 8'h77);
    end

    // Reset in the middle of AWAIT with five entries queued.
    do_reset();
    log_q.delete();
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 8'(8'h90 + i));
    chk("t5_level", int'(level), 5);
    chk("t5_addr_seen", int'(chip_din), 8'h30);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t5");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    nd = 0;
    foreach (log_q[i]) if (log_q[i].a) nd++;
    chk("t5_no_data", nd, 0);
    chk("t5_nlog", log_q.size(), 1);
    chk("t5_idle", int'(idle), 1);

`ifdef JT03_WRQ_BUSY_EN
    // Status polling: busy held for 10 ticks after the data write.
    do_reset();
    log_q.delete();
    chip_dout = 8'h80;
    push(8'h11, 8'h22);
    push(8'h33, 8'h44);
    wait_strobe(1'b1, 100, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_cs_n", int'(chip_cs_n), 0);
      chk("t6_wr_n", int'(chip_wr_n), 1);
    end
    chip_dout = 8'h00;
    wait_strobe(1'b0, 100, at);
    chk("t6_next_addr", at, d + 13);
    chk("t6_next_din", int'(chip_din), 8'h33);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
